regfile_wb_queue: RTL

- Writeback stage directly upstream of the 32x64 register file write port.
- Merges register writeback requests from two producers: the ALU (channel A) and the load unit (channel B).
- Arbitrates between them round-robin and buffers accepted writes in a small FIFO.
- Drains one write per cycle into the register file, and flags read-after-write hazards for both register-file read addresses while writes are still pending.

---
 rtl/regfile_wb_queue.sv | 125 ++++++++++++
 1 files changed

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the register-file write port.
// It arbitrates ALU and load writebacks round-robin, buffers them in order, and drains one per cycle.
module regfile_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              flush,
  output logic              write,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddrA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic              hazardA,
  output logic              hazardB,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic {PRIO_A, PRIO_B} prio_e;

  prio_e             prio_q, prio_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic full, a_acc, b_acc, enq, deq;
  logic [PTR_W-1:0] offset;

  // Readiness is gated by rst_n so nothing appears accepted while reset is held.
  always_comb begin
    full    = (count_q == CNT_W'(DEPTH));
    a_ready = rst_n && !flush && !full && (prio_q == PRIO_A || !b_valid);
    b_ready = rst_n && !flush && !full && (prio_q == PRIO_B || !a_valid);
    a_acc   = a_valid && a_ready;
    b_acc   = b_valid && b_ready;
    enq     = a_acc || b_acc;
    deq     = (count_q != '0);
  end

  always_comb begin
    write   = deq;
    wrAddr  = '0;
    wrData  = '0;
    hazardA = 1'b0;
    hazardB = 1'b0;
    offset  = '0;
    if (deq) begin
      wrAddr = addr_q[rd_ptr_q];
      wrData = data_q[rd_ptr_q];
    end
    // An entry is live when its distance from the read pointer is below the occupancy.
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr_q;
      if (CNT_W'(offset) < count_q) begin
        if (addr_q[i] == rdAddrA) hazardA = 1'b1;
        if (addr_q[i] == rdAddrB) hazardB = 1'b1;
      end
    end
  end

  assign count = count_q;

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    prio_d   = prio_q;
    count_d  = count_q;
    if (a_acc) begin
      addr_d[wr_ptr_q] = a_addr;
      data_d[wr_ptr_q] = a_data;
      prio_d           = PRIO_B;
    end else if (b_acc) begin
      addr_d[wr_ptr_q] = b_addr;
      data_d[wr_ptr_q] = b_data;
      prio_d           = PRIO_A;
    end
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q   <= PRIO_A;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      prio_q   <= prio_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

endmodule
